// File: rtl/dcache_data_responder.sv
// Data-side responder for the pipeline's M1 data-request interface.
// Serves one load/store at a time over split read/write channels and keeps a one-entry posted write buffer.
module dcache_data_responder #(
    parameter bit WBUF_EN = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    // pipeline side
    input  logic        data_valid,
    input  logic        data_op,
    input  logic [19:0] data_tag,
    input  logic [7:0]  data_index,
    input  logic [3:0]  data_offset,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    input  logic        isUncache,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    // read channel
    output logic        rd_req,
    output logic [31:0] rd_addr,
    input  logic        rd_rdy,
    input  logic        ret_valid,
    input  logic [31:0] ret_data,
    // write channel
    output logic        wr_req,
    output logic [31:0] wr_addr,
    output logic [3:0]  wr_strb,
    output logic [31:0] wr_data,
    input  logic        wr_rdy,
    input  logic        wr_bvalid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB_DRAIN,
        S_RD_REQ,
        S_RD_WAIT,
        S_RESP
    } state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_REQ,
        W_WAIT
    } wstate_e;

    state_e      state_q, state_d;
    wstate_e     wstate_q, wstate_d;

    logic        req_op_q, req_op_d;
    logic        req_unc_q, req_unc_d;
    logic        req_buffered_q, req_buffered_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [3:0]  req_wstrb_q, req_wstrb_d;
    logic [31:0] req_wdata_q, req_wdata_d;

    logic        wbuf_valid_q, wbuf_valid_d;
    logic [31:0] wbuf_addr_q, wbuf_addr_d;
    logic [3:0]  wbuf_strb_q, wbuf_strb_d;
    logic [31:0] wbuf_data_q, wbuf_data_d;

    logic [31:0] rdata_q, rdata_d;

    logic        accept;
    logic [31:0] in_addr;
    logic        wbuf_load;
    logic        wbuf_clear;

    // Byte offset within the word is the initiator's concern; only the word address is kept.
    logic        unused_offset_lo;
    assign unused_offset_lo = ^data_offset[1:0];

    assign in_addr = {data_tag, data_index, data_offset[3:2], 2'b00};
    assign accept  = data_valid && (state_q == S_IDLE);

    // Main request FSM
    always_comb begin
        state_d        = state_q;
        req_op_d       = req_op_q;
        req_unc_d      = req_unc_q;
        req_buffered_d = req_buffered_q;
        req_addr_d     = req_addr_q;
        req_wstrb_d    = req_wstrb_q;
        req_wdata_d    = req_wdata_q;
        rdata_d        = rdata_q;
        wbuf_load      = 1'b0;
        wbuf_addr_d    = wbuf_addr_q;
        wbuf_strb_d    = wbuf_strb_q;
        wbuf_data_d    = wbuf_data_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    req_op_d       = data_op;
                    req_unc_d      = isUncache;
                    req_addr_d     = in_addr;
                    req_wstrb_d    = data_wstrb;
                    req_wdata_d    = data_wdata;
                    req_buffered_d = 1'b0;
                    if (wbuf_valid_q) begin
                        state_d = S_WB_DRAIN;
                    end else if (!data_op) begin
                        state_d = S_RD_REQ;
                    end else begin
                        wbuf_load      = 1'b1;
                        wbuf_addr_d    = in_addr;
                        wbuf_strb_d    = data_wstrb;
                        wbuf_data_d    = data_wdata;
                        req_buffered_d = 1'b1;
                        state_d        = (WBUF_EN && !isUncache) ? S_RESP : S_WB_DRAIN;
                    end
                end
            end
            S_WB_DRAIN: begin
                if (!wbuf_valid_q) begin
                    if (!req_op_q) begin
                        state_d = S_RD_REQ;
                    end else if (!req_buffered_q) begin
                        wbuf_load      = 1'b1;
                        wbuf_addr_d    = req_addr_q;
                        wbuf_strb_d    = req_wstrb_q;
                        wbuf_data_d    = req_wdata_q;
                        req_buffered_d = 1'b1;
                        state_d        = (WBUF_EN && !req_unc_q) ? S_RESP : S_WB_DRAIN;
                    end else begin
                        // Uncached or unbuffered store whose write has now completed
                        state_d = S_RESP;
                    end
                end
            end
            S_RD_REQ: begin
                if (rd_rdy) begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (ret_valid) begin
                    rdata_d = ret_data;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Write-buffer drain FSM, independent of the main FSM
    always_comb begin
        wstate_d   = wstate_q;
        wbuf_clear = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (wbuf_valid_q) begin
                    wstate_d = W_REQ;
                end
            end
            W_REQ: begin
                if (wr_rdy) begin
                    wstate_d = W_WAIT;
                end
            end
            W_WAIT: begin
                if (wr_bvalid) begin
                    wbuf_clear = 1'b1;
                    wstate_d   = W_IDLE;
                end
            end
            default: begin
                wstate_d = W_IDLE;
            end
        endcase
    end

    // Load only happens while empty and clear only while full, so they never collide.
    always_comb begin
        wbuf_valid_d = wbuf_valid_q;
        if (wbuf_load) begin
            wbuf_valid_d = 1'b1;
        end else if (wbuf_clear) begin
            wbuf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= S_IDLE;
            wstate_q       <= W_IDLE;
            req_op_q       <= 1'b0;
            req_unc_q      <= 1'b0;
            req_buffered_q <= 1'b0;
            req_addr_q     <= '0;
            req_wstrb_q    <= '0;
            req_wdata_q    <= '0;
            wbuf_valid_q   <= 1'b0;
            wbuf_addr_q    <= '0;
            wbuf_strb_q    <= '0;
            wbuf_data_q    <= '0;
            rdata_q        <= '0;
        end else begin
            state_q        <= state_d;
            wstate_q       <= wstate_d;
            req_op_q       <= req_op_d;
            req_unc_q      <= req_unc_d;
            req_buffered_q <= req_buffered_d;
            req_addr_q     <= req_addr_d;
            req_wstrb_q    <= req_wstrb_d;
            req_wdata_q    <= req_wdata_d;
            wbuf_valid_q   <= wbuf_valid_d;
            wbuf_addr_q    <= wbuf_addr_d;
            wbuf_strb_q    <= wbuf_strb_d;
            wbuf_data_q    <= wbuf_data_d;
            rdata_q        <= rdata_d;
        end
    end

    // addr_ok depends only on registered state, so the initiator may gate data_valid with it.
    assign data_addr_ok = (state_q == S_IDLE);
    assign data_data_ok = (state_q == S_RESP);
    assign data_rdata   = rdata_q;

    assign rd_req  = (state_q == S_RD_REQ);
    assign rd_addr = rd_req ? req_addr_q : '0;

    assign wr_req  = (wstate_q == W_REQ);
    assign wr_addr = wr_req ? wbuf_addr_q : '0;
    assign wr_strb = wr_req ? wbuf_strb_q : '0;
    assign wr_data = wr_req ? wbuf_data_q : '0;

endmodule

// File: tb/tb_dcache_data_responder.sv
// Directed bench for dcache_data_responder: behavioural memory with programmable
// read-accept and write-response delays, hand-computed latencies and write ordering.
module tb_dcache_data_responder;

    logic        clk;
    logic        resetn;
    logic        data_valid;
    logic        data_op;
    logic [19:0] data_tag;
    logic [7:0]  data_index;
    logic [3:0]  data_offset;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        isUncache;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_rdy;
    logic        ret_valid;
    logic [31:0] ret_data;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [3:0]  wr_strb;
    logic [31:0] wr_data;
    logic        wr_rdy;
    logic        wr_bvalid;

    dcache_data_responder #(.WBUF_EN(1'b1)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .data_valid   (data_valid),
        .data_op      (data_op),
        .data_tag     (data_tag),
        .data_index   (data_index),
        .data_offset  (data_offset),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .isUncache    (isUncache),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_rdy       (rd_rdy),
        .ret_valid    (ret_valid),
        .ret_data     (ret_data),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_strb      (wr_strb),
        .wr_data      (wr_data),
        .wr_rdy       (wr_rdy),
        .wr_bvalid    (wr_bvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // memory model controls and observations
    int          rd_delay   = 0;
    int          bv_delay   = 0;
    bit          rd_hold    = 1'b0;
    logic [31:0] rd_value   = 32'h0;
    int          bv_count   = 0;
    int          rd_need_bv = -1;
    int          last_rd_cycles;
    logic [31:0] wlog_addr[$];
    logic [3:0]  wlog_strb[$];
    logic [31:0] wlog_data[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory: samples on the falling edge, handshakes complete on the next rising edge.
    initial begin
        int rphase;
        int rcnt;
        int wphase;
        int wcnt;
        rphase = 0; rcnt = 0; wphase = 0; wcnt = 0;
        rd_rdy = 1'b0; ret_valid = 1'b0; ret_data = '0;
        wr_rdy = 1'b0; wr_bvalid = 1'b0;
        forever begin
            @(negedge clk);
            rd_rdy    = 1'b0;
            wr_rdy    = 1'b0;
            wr_bvalid = 1'b0;
            if (!rd_hold) ret_valid = 1'b0;
            if (!resetn) begin
                rphase = 0; rcnt = 0; wphase = 0; wcnt = 0;
            end else begin
                if (rphase == 0) begin
                    if (rd_req) begin
                        if (rcnt >= rd_delay) begin
                            rd_rdy = 1'b1; rphase = 1; rcnt = 0;
                        end else begin
                            rcnt++;
                        end
                    end
                end else begin
                    rphase = 0;
                    if (!rd_hold) begin
                        ret_valid = 1'b1;
                        ret_data  = rd_value;
                    end
                end
                if (wphase == 0) begin
                    if (wr_req) begin
                        wr_rdy = 1'b1; wphase = 1; wcnt = 0;
                        wlog_addr.push_back(wr_addr);
                        wlog_strb.push_back(wr_strb);
                        wlog_data.push_back(wr_data);
                    end
                end else begin
                    if (wcnt >= bv_delay) begin
                        wr_bvalid = 1'b1; wphase = 0; wcnt = 0; bv_count++;
                    end else begin
                        wcnt++;
                    end
                end
            end
        end
    end

    // Issue one request, measure cycles from acceptance edge to data_ok, check the pulse is single.
    task automatic do_req(input string tag, input logic op, input logic [31:0] addr,
                          input logic [3:0] strb, input logic [31:0] wd, input logic unc,
                          input int exp_lat, input logic [31:0] exp_rdata, input bit chk_busy);
        int guard;
        int cyc;
        guard = 0;
        while (!data_addr_ok && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        check({tag, "_addr_ok"}, {31'b0, data_addr_ok}, 32'd1);
        data_valid  = 1'b1;
        data_op     = op;
        data_tag    = addr[31:12];
        data_index  = addr[11:4];
        data_offset = addr[3:0];
        data_wstrb  = strb;
        data_wdata  = wd;
        isUncache   = unc;
        @(posedge clk); #1;
        data_valid  = 1'b0;
        last_rd_cycles = 0;
        cyc = 1;
        while (!data_data_ok && cyc < 60) begin
            if (chk_busy) check({tag, "_busy"}, {31'b0, data_addr_ok}, 32'd0);
            if (rd_req) begin
                last_rd_cycles++;
                check({tag, "_rd_addr"}, rd_addr, {addr[31:2], 2'b00});
                if (rd_need_bv >= 0) check({tag, "_rd_order"}, (bv_count >= rd_need_bv) ? 32'd1 : 32'd0, 32'd1);
            end
            @(posedge clk); #1; cyc++;
        end
        check({tag, "_latency"}, cyc, exp_lat);
        if (!op) check({tag, "_rdata"}, data_rdata, exp_rdata);
        @(posedge clk); #1;
        check({tag, "_pulse"}, {31'b0, data_data_ok}, 32'd0);
    endtask

    task automatic wait_bv(input string tag, input int target);
        int guard;
        guard = 0;
        while (bv_count < target && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        check({tag, "_drained"}, (bv_count >= target) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int bv0;
        resetn = 1'b0; data_valid = 1'b0; data_op = 1'b0; data_tag = '0; data_index = '0;
        data_offset = '0; data_wstrb = '0; data_wdata = '0; isUncache = 1'b0;
        #12;
        check("rst_addr_ok", {31'b0, data_addr_ok}, 32'd1);
        check("rst_data_ok", {31'b0, data_data_ok}, 32'd0);
        check("rst_rdata",   data_rdata, 32'h0);
        check("rst_rd_req",  {31'b0, rd_req}, 32'd0);
        check("rst_wr_req",  {31'b0, wr_req}, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        // cached store, empty buffer
        bv_delay = 0;
        do_req("st_cached", 1'b1, 32'h8000_1234, 4'hF, 32'hDEAD_BEEF, 1'b0, 1, 32'h0, 1'b0);
        wait_bv("st_cached", 1);
        check("st_cached_nwr", wlog_addr.size(), 32'd1);
        check("st_cached_waddr", wlog_addr[0], 32'h8000_1234);
        check("st_cached_wdata", wlog_data[0], 32'hDEAD_BEEF);
        check("st_cached_wstrb", {28'b0, wlog_strb[0]}, 32'hF);

        // load with rd_rdy delayed 3 cycles
        rd_delay = 3; rd_value = 32'h1234_5678;
        do_req("ld_slow", 1'b0, 32'h0000_0100, 4'h0, 32'h0, 1'b0, 6, 32'h1234_5678, 1'b0);
        check("ld_slow_rd_cycles", last_rd_cycles, 32'd4);

        // store then load, write response delayed 5 cycles
        rd_delay = 0; bv_delay = 5; rd_value = 32'hCAFE_F00D;
        bv0 = bv_count;
        do_req("st_then", 1'b1, 32'h0000_2000, 4'hF, 32'hA5A5_A5A5, 1'b0, 1, 32'h0, 1'b0);
        rd_need_bv = bv0 + 1;
        do_req("ld_after", 1'b0, 32'h0000_3000, 4'h0, 32'h0, 1'b0, 10, 32'hCAFE_F00D, 1'b0);
        rd_need_bv = -1;
        check("ld_after_waddr", wlog_addr[1], 32'h0000_2000);

        // uncached half-word store; offset[1:0] must be dropped
        bv_delay = 2;
        bv0 = bv_count;
        do_req("st_unc", 1'b1, 32'h0000_400B, 4'b0011, 32'h0000_BEEF, 1'b1, 7, 32'h0, 1'b1);
        check("st_unc_bv_before_ok", bv_count, bv0 + 1);
        check("st_unc_waddr", wlog_addr[2], 32'h0000_4008);
        check("st_unc_wstrb", {28'b0, wlog_strb[2]}, 32'h3);
        check("st_unc_wdata", wlog_data[2], 32'h0000_BEEF);

        // back-to-back cached stores, first still draining
        bv_delay = 3;
        bv0 = bv_count;
        do_req("b2b_first", 1'b1, 32'h0000_5000, 4'hF, 32'h1111_1111, 1'b0, 1, 32'h0, 1'b0);
        do_req("b2b_second", 1'b1, 32'h0000_5004, 4'hC, 32'h2222_2222, 1'b0, 6, 32'h0, 1'b1);
        wait_bv("b2b", bv0 + 2);
        check("b2b_nwr", wlog_addr.size(), 32'd5);
        check("b2b_addr0", wlog_addr[3], 32'h0000_5000);
        check("b2b_data0", wlog_data[3], 32'h1111_1111);
        check("b2b_addr1", wlog_addr[4], 32'h0000_5004);
        check("b2b_data1", wlog_data[4], 32'h2222_2222);
        check("b2b_strb1", {28'b0, wlog_strb[4]}, 32'hC);

        // reset while waiting for read data
        rd_hold = 1'b1; bv_delay = 0;
        data_valid = 1'b1; data_op = 1'b0; data_tag = 20'h0; data_index = 8'h60;
        data_offset = 4'h0; isUncache = 1'b0;
        @(posedge clk); #1;
        data_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rw_busy", {31'b0, data_addr_ok}, 32'd0);
        resetn = 1'b0;
        #1;
        check("rw_rst_data_ok", {31'b0, data_data_ok}, 32'd0);
        check("rw_rst_rdata", data_rdata, 32'h0);
        check("rw_rst_rd_req", {31'b0, rd_req}, 32'd0);
        check("rw_rst_rd_addr", rd_addr, 32'h0);
        check("rw_rst_wr_req", {31'b0, wr_req}, 32'd0);
        check("rw_rst_wr_data", wr_data, 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        check("rw_addr_ok", {31'b0, data_addr_ok}, 32'd1);
        ret_valid = 1'b1; ret_data = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        ret_valid = 1'b0;
        check("rw_stale_ok0", {31'b0, data_data_ok}, 32'd0);
        @(posedge clk); #1;
        check("rw_stale_ok1", {31'b0, data_data_ok}, 32'd0);
        check("rw_stale_rdata", data_rdata, 32'h0);
        rd_hold = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
